// File: rtl/gf_vme_slave_cycle_if.sv
// VME A24/D16 slave-side bus bundle: strobes, address/modifier, data in/out, DTACK.
// The master modport is the bus side (or a bench), the slave modport is the cycle handler.
interface gf_vme_slave_cycle_if;
   logic        vme_as_n;
   logic        vme_ds0_n;
   logic        vme_ds1_n;
   logic        vme_write_n;
   logic [5:0]  vme_am;
   logic [22:0] vme_addr;
   logic [15:0] vme_data_in;
   logic [15:0] vme_data_out;
   logic        vme_data_oe;
   logic        vme_dtack;

   modport master (
      output vme_as_n, vme_ds0_n, vme_ds1_n, vme_write_n,
      output vme_am, vme_addr, vme_data_in,
      input  vme_data_out, vme_data_oe, vme_dtack
   );

   modport slave (
      input  vme_as_n, vme_ds0_n, vme_ds1_n, vme_write_n,
      input  vme_am, vme_addr, vme_data_in,
      output vme_data_out, vme_data_oe, vme_dtack
   );
endinterface

// File: rtl/gf_vme_slave_cycle.sv
// VME A24/D16 slave cycle handler: synchronises strobes, qualifies board/AM, holds one
// steady access level per VME cycle for the downstream pulse decoder, and drives DTACK.
module gf_vme_slave_cycle #(
   parameter logic [6:0]  BOARD_BASE    = 7'h00,
   parameter int unsigned ACCESS_CYCLES = 4,
   parameter logic [5:0]  AM_DATA0      = 6'h39,
   parameter logic [5:0]  AM_DATA1      = 6'h3D
) (
   input  logic                       clk,
   input  logic                       init,
   gf_vme_slave_cycle_if.slave        vme,
   output logic [15:0]                address,
   output logic                       writeAccess,
   output logic                       readAccess,
   output logic [15:0]                wr_data,
   input  logic [15:0]                rd_data
);

   localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DTACK,
      RELEASE
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [1:0]  as_sync;
   logic [1:0]  ds0_sync;
   logic [1:0]  ds1_sync;
   logic [1:0]  write_sync;
   logic        as_s;
   logic        ds0_s;
   logic        ds1_s;
   logic        write_s;

   logic [3:0]  cnt;
   logic        is_write;
   logic [15:0] data_out;

   logic        am_ok;
   logic        board_ok;
   logic        start;
   logic        load;
   logic        capture;

   // Two-stage synchronisers; reset to the inactive (high) level.
   always_ff @(posedge clk) begin
      if (init) begin
         as_sync    <= '1;
         ds0_sync   <= '1;
         ds1_sync   <= '1;
         write_sync <= '1;
      end else begin
         as_sync    <= {as_sync[0],    vme.vme_as_n};
         ds0_sync   <= {ds0_sync[0],   vme.vme_ds0_n};
         ds1_sync   <= {ds1_sync[0],   vme.vme_ds1_n};
         write_sync <= {write_sync[0], vme.vme_write_n};
      end
   end

   assign as_s    = as_sync[1];
   assign ds0_s   = ds0_sync[1];
   assign ds1_s   = ds1_sync[1];
   assign write_s = write_sync[1];

   // am/addr are only looked at once both DS are low, where VME guarantees stability.
   assign am_ok    = (vme.vme_am == AM_DATA0) || (vme.vme_am == AM_DATA1);
   assign board_ok = (vme.vme_addr[22:16] == BOARD_BASE);
   assign start    = !as_s && !ds0_s && !ds1_s && am_ok && board_ok;

   always_ff @(posedge clk) begin
      if (init) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next      = state;
      load            = 1'b0;
      capture         = 1'b0;
      writeAccess     = 1'b0;
      readAccess      = 1'b0;
      vme.vme_dtack   = 1'b0;
      vme.vme_data_oe = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            writeAccess = is_write;
            readAccess  = !is_write;
            // Abort wins over completion so a withdrawn master never sees DTACK.
            if (as_s) begin
               state_next = RELEASE;
            end else if (cnt == CNT_LAST) begin
               capture    = !is_write;
               state_next = DTACK;
            end
         end
         DTACK: begin
            writeAccess     = is_write;
            readAccess      = !is_write;
            vme.vme_dtack   = 1'b1;
            vme.vme_data_oe = !is_write;
            if (ds0_s && ds1_s) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (init) begin
         cnt      <= '0;
         is_write <= 1'b0;
         address  <= '0;
         wr_data  <= '0;
         data_out <= '0;
      end else begin
         if (load) begin
            cnt      <= '0;
            is_write <= !write_s;
            address  <= vme.vme_addr[15:0];
            wr_data  <= vme.vme_data_in;
         end else if (state == ACCESS) begin
            cnt <= cnt + 4'd1;
         end
         if (capture) begin
            data_out <= rd_data;
         end
      end
   end

   assign vme.vme_data_out = data_out;

endmodule

// File: tb/tb_gf_vme_slave_cycle.sv
// Randomised VME cycle bench for gf_vme_slave_cycle with a per-transaction reference model.
module tb_gf_vme_slave_cycle;

   localparam logic [6:0]  BASE = 7'h05;
   localparam int unsigned AC   = 4;

   logic        clk;
   logic        init;
   logic [15:0] address;
   logic        writeAccess;
   logic        readAccess;
   logic [15:0] wr_data;
   logic [15:0] rd_data;

   gf_vme_slave_cycle_if bus ();

   gf_vme_slave_cycle #(
      .BOARD_BASE    (BASE),
      .ACCESS_CYCLES (AC),
      .AM_DATA0      (6'h39),
      .AM_DATA1      (6'h3D)
   ) dut (
      .clk         (clk),
      .init        (init),
      .vme         (bus),
      .address     (address),
      .writeAccess (writeAccess),
      .readAccess  (readAccess),
      .wr_data     (wr_data),
      .rd_data     (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: values the slave should be holding between cycles.
   logic [15:0] last_addr = '0;
   logic [15:0] last_wr   = '0;
   logic [15:0] last_out  = '0;

   // Decoder emulation and event counters, sampled mid-cycle.
   int wp_cnt = 0, rp_cnt = 0, both_cnt = 0, dt_cnt = 0, acc_cnt = 0;
   logic prev_wa = 1'b0, prev_ra = 1'b0;

   always @(negedge clk) begin
      if (writeAccess && !prev_wa) wp_cnt++;
      if (readAccess && !prev_ra) rp_cnt++;
      if (writeAccess && readAccess) both_cnt++;
      if (bus.vme_dtack) dt_cnt++;
      if (writeAccess || readAccess) acc_cnt++;
      prev_wa = writeAccess;
      prev_ra = readAccess;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic release_bus();
      bus.vme_as_n    = 1'b1;
      bus.vme_ds0_n   = 1'b1;
      bus.vme_ds1_n   = 1'b1;
      bus.vme_write_n = 1'b1;
   endtask

   // mode: 0 normal, 1 single-DS, 2 abort after access seen, 3 init during DTACK
   task automatic run_cycle(input logic wr, input logic [23:0] a24, input logic [5:0] am,
                            input logic [15:0] data, input logic [15:0] rdv, input int mode);
      logic accepted;
      int   w0, r0, b0, d0, a0;
      int   n, m, fa;
      accepted = (mode != 1) && (am == 6'h39 || am == 6'h3D) && (a24[23:17] == BASE);
      @(negedge clk);
      bus.vme_am      = am;
      bus.vme_addr    = a24[23:1];
      bus.vme_write_n = !wr;
      bus.vme_data_in = data;
      rd_data         = rdv;
      bus.vme_as_n    = 1'b0;
      bus.vme_ds0_n   = 1'b0;
      bus.vme_ds1_n   = (mode == 1);
      w0 = wp_cnt; r0 = rp_cnt; b0 = both_cnt; d0 = dt_cnt; a0 = acc_cnt;

      if (!accepted) begin
         repeat (AC + 8) @(posedge clk);
         @(negedge clk);
         release_bus();
         repeat (4) @(posedge clk);
         #1;
         check("rej_dtack", 32'(dt_cnt - d0), 0);
         check("rej_access", 32'(acc_cnt - a0), 0);
         check("rej_addr_hold", address, last_addr);
         check("rej_wr_hold", wr_data, last_wr);
         check("rej_out_hold", bus.vme_data_out, last_out);
      end else if (mode == 2) begin
         n = -1;
         for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (writeAccess || readAccess) break;
         end
         check("abort_acc_lat", n, 2);
         last_addr = a24[16:1];
         last_wr   = data;
         @(negedge clk);
         release_bus();
         repeat (2) @(posedge clk);
         #1;
         check("abort_level_held", {writeAccess, readAccess}, {wr, !wr});
         @(posedge clk);
         #1;
         check("abort_level_drop", {writeAccess, readAccess}, 2'b00);
         repeat (4) @(posedge clk);
         #1;
         check("abort_no_dtack", 32'(dt_cnt - d0), 0);
         check("abort_out_hold", bus.vme_data_out, last_out);
         check("abort_pulses", {16'(wp_cnt - w0), 16'(rp_cnt - r0)}, {16'(wr), 16'(!wr)});
      end else begin
         n  = -1;
         fa = -1;
         for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            n++;
            #1;
            if (fa < 0 && (writeAccess || readAccess)) fa = n;
            if (bus.vme_dtack) break;
         end
         check("acc_lat", fa, 2);
         check("dtack_lat", n, 2 + AC);
         last_addr = a24[16:1];
         last_wr   = data;
         if (!wr) last_out = rdv;
         check("address", address, last_addr);
         check("wr_data", wr_data, last_wr);
         check("data_out", bus.vme_data_out, last_out);
         check("oe", bus.vme_data_oe, !wr);
         check("levels", {writeAccess, readAccess}, {wr, !wr});
         if (mode == 3) begin
            @(negedge clk);
            init = 1'b1;
            @(posedge clk);
            #1;
            check("init_outputs", {bus.vme_dtack, bus.vme_data_oe, writeAccess, readAccess}, 4'b0000);
            check("init_regs", {address, wr_data, bus.vme_data_out}, 48'h0);
            @(negedge clk);
            release_bus();
            repeat (3) @(posedge clk);
            @(negedge clk);
            init = 1'b0;
            last_addr = '0;
            last_wr   = '0;
            last_out  = '0;
         end else begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check("dtack_hold", {bus.vme_dtack, writeAccess, readAccess}, {1'b1, wr, !wr});
            @(negedge clk);
            release_bus();
            m = -1;
            for (int k = 0; k < 20; k++) begin
               @(posedge clk);
               m++;
               #1;
               if (!bus.vme_dtack) break;
            end
            check("dtack_drop", m, 2);
            check("release_idle", {bus.vme_data_oe, writeAccess, readAccess}, 3'b000);
         end
         check("pulses", {16'(wp_cnt - w0), 16'(rp_cnt - r0)}, {16'(wr), 16'(!wr)});
      end
      check("never_both", 32'(both_cnt - b0), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        wr;
      logic [23:0] a24;
      logic [5:0]  am;
      int          sel;

      init            = 1'b1;
      rd_data         = '0;
      bus.vme_am      = '0;
      bus.vme_addr    = '0;
      bus.vme_data_in = '0;
      release_bus();
      repeat (4) @(posedge clk);
      #1;
      check("reset_outputs", {bus.vme_dtack, bus.vme_data_oe, writeAccess, readAccess}, 4'b0000);
      check("reset_regs", {address, wr_data, bus.vme_data_out}, 48'h0);
      @(negedge clk);
      init = 1'b0;
      repeat (2) @(posedge clk);

      run_cycle(1'b1, 24'h0A0010, 6'h39, 16'hBEEF, 16'h0000, 0);
      check("s1_address", address, 16'h0008);
      run_cycle(1'b0, 24'h0A0010, 6'h3D, 16'h0000, 16'h1234, 0);
      check("s2_read", bus.vme_data_out, 16'h1234);
      run_cycle(1'b1, 24'h0A0020, 6'h29, 16'h5555, 16'h0000, 0);
      run_cycle(1'b1, 24'h0C0020, 6'h39, 16'h6666, 16'h0000, 0);
      run_cycle(1'b1, 24'h0A0040, 6'h39, 16'h7777, 16'h0000, 1);
      run_cycle(1'b0, 24'h0A0030, 6'h39, 16'h0000, 16'hAAAA, 2);
      run_cycle(1'b0, 24'h0A0050, 6'h39, 16'h0000, 16'h4321, 3);
      run_cycle(1'b1, 24'h0A0010, 6'h39, 16'hBEEF, 16'h0000, 0);
      check("s5_address", address, 16'h0008);
      run_cycle(1'b1, 24'h0BFFFE, 6'h39, 16'hC0DE, 16'h0000, 0);
      run_cycle(1'b0, 24'h0A0002, 6'h3D, 16'h0000, 16'hF00D, 0);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         wr  = 1'($urandom_range(0, 1));
         a24 = {BASE, 17'($urandom)};
         am  = ($urandom_range(0, 1) != 0) ? 6'h39 : 6'h3D;
         if (sel == 5) begin
            am = 6'($urandom);
            if (am == 6'h39 || am == 6'h3D) am = 6'h09;
         end
         if (sel == 6) a24[23:17] = BASE ^ 7'(1 + $urandom_range(0, 126));
         case (sel)
            7:       run_cycle(wr, a24, am, 16'($urandom), 16'($urandom), 1);
            8:       run_cycle(wr, a24, am, 16'($urandom), 16'($urandom), 2);
            9:       run_cycle(1'b0, a24, am, 16'($urandom), 16'($urandom), 3);
            default: run_cycle(wr, a24, am, 16'($urandom), 16'($urandom), 0);
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
